if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/if_fetch_stage_if_id_reg.sv | 37 +++
 rtl/if_fetch_stage.sv | 88 ++++++++
 tb/tb_if_fetch_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch/decode constants: instruction width, alignment, reset PC and bubble word.
// Also holds the fetch state encoding and a word-alignment helper.
package if_fetch_stage_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          WORD_BYTES       = 4;
    localparam int          ALIGN_BITS       = 2;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic {
        FETCH = 1'b0,
        DONE  = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a fetched word,
// otherwise the contents hold (stall).
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [31:0]        pc4_d,
    output logic [INSTR_W-1:0] instr_q,
    output logic [31:0]        pc4_q,
    output logic               valid_q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (flush) begin
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (load) begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, FETCH/DONE state machine, retired-fetch counter,
// and the IF/ID register fed from a combinational instruction memory.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0]        RESET_PC   = DEFAULT_RESET_PC,
    parameter int                 IMEM_BYTES = 24,
    parameter logic [INSTR_W-1:0] NOP_WORD   = DEFAULT_NOP_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [31:0]        pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic               fetch_done,
    output logic [31:0]        fetch_count
);

    fetch_state_e state, state_next;
    logic         in_range;
    logic         load;
    logic         flush;
    logic [31:0]  pc_plus4;

    assign pc_plus4  = pc + 32'(WORD_BYTES);
    // 33-bit sum so a PC near 2^32 cannot wrap back into range.
    assign in_range  = ({1'b0, pc} + 33'(WORD_BYTES)) <= 33'(IMEM_BYTES);
    assign imem_addr = pc;
    assign fetch_done = (state == DONE);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            state_next = FETCH;
            flush      = 1'b1;
        end else if (!stall) begin
            if (state == DONE || !in_range) begin
                state_next = DONE;
                flush      = 1'b1;
            end else begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            fetch_count <= 32'h0;
        end else begin
            state <= state_next;
            if (redirect) begin
                pc <= word_align(redirect_pc);
            end else if (load) begin
                pc <= pc_plus4;
            end
            if (load && fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .flush   (flush),
        .instr_d (imem_instr),
        .pc4_d   (pc_plus4),
        .instr_q (if_id_instr),
        .pc4_q   (if_id_pc4),
        .valid_q (if_id_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, async-reset sequence, and
// randomized stall/redirect traffic checked against a cycle-level reference model.
module tb_if_fetch_stage;

    localparam int IMEM_BYTES = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_done;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:IMEM_BYTES-1];

    if_fetch_stage #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (IMEM_BYTES),
        .NOP_WORD   (32'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .fetch_done  (fetch_done),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    // Big-endian combinational memory; out-of-range reads return a marker word.
    always_comb begin
        imem_instr = 32'hDEAD_BEEF;
        if (imem_addr <= 32'(IMEM_BYTES - 4) && imem_addr[1:0] == 2'b00) begin
            imem_instr = {mem[imem_addr[4:0]],        mem[imem_addr[4:0] + 5'd1],
                          mem[imem_addr[4:0] + 5'd2], mem[imem_addr[4:0] + 5'd3]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    // Reference model state, advanced from the fetch rules once per edge.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_done;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_count = 32'h0; m_valid = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] rp);
        if (r) begin
            m_pc    = rp & ~32'h3;
            m_valid = 1'b0;
            m_instr = 32'h0;
            m_done  = 1'b0;
        end else if (!s) begin
            if (m_done || (longint'(m_pc) + 4 > longint'(IMEM_BYTES))) begin
                m_done  = 1'b1;
                m_valid = 1'b0;
                m_instr = 32'h0;
            end else begin
                m_instr = word_at(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            end
        end
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic        e_done;
        logic [31:0] e_count;
    } vec_t;

    vec_t tbl [17];

    initial begin
        for (int a = 0; a < IMEM_BYTES; a += 4) begin
            logic [31:0] w;
            w = word_at(32'(a));
            mem[a]     = w[31:24];
            mem[a + 1] = w[23:16];
            mem[a + 2] = w[15:8];
            mem[a + 3] = w[7:0];
        end

        //          stall redir rpc       pc        instr          pc4     v     done  count
        tbl[0]  = '{1'b0, 1'b0, 32'h00, 32'd4,  32'hC0DE_0000, 32'd4,  1'b1, 1'b0, 32'd1};
        tbl[1]  = '{1'b0, 1'b0, 32'h00, 32'd8,  32'hC0DE_0004, 32'd8,  1'b1, 1'b0, 32'd2};
        tbl[2]  = '{1'b1, 1'b0, 32'h00, 32'd8,  32'hC0DE_0004, 32'd8,  1'b1, 1'b0, 32'd2};
        tbl[3]  = '{1'b1, 1'b0, 32'h00, 32'd8,  32'hC0DE_0004, 32'd8,  1'b1, 1'b0, 32'd2};
        tbl[4]  = '{1'b1, 1'b0, 32'h00, 32'd8,  32'hC0DE_0004, 32'd8,  1'b1, 1'b0, 32'd2};
        tbl[5]  = '{1'b0, 1'b0, 32'h00, 32'd12, 32'hC0DE_0008, 32'd12, 1'b1, 1'b0, 32'd3};
        tbl[6]  = '{1'b0, 1'b1, 32'h10, 32'd16, 32'h0,         32'd0,  1'b0, 1'b0, 32'd3};
        tbl[7]  = '{1'b0, 1'b0, 32'h00, 32'd20, 32'hC0DE_0010, 32'd20, 1'b1, 1'b0, 32'd4};
        tbl[8]  = '{1'b0, 1'b0, 32'h00, 32'd24, 32'hC0DE_0014, 32'd24, 1'b1, 1'b0, 32'd5};
        tbl[9]  = '{1'b0, 1'b0, 32'h00, 32'd24, 32'h0,         32'd0,  1'b0, 1'b1, 32'd5};
        tbl[10] = '{1'b0, 1'b0, 32'h00, 32'd24, 32'h0,         32'd0,  1'b0, 1'b1, 32'd5};
        tbl[11] = '{1'b1, 1'b1, 32'h06, 32'd4,  32'h0,         32'd0,  1'b0, 1'b0, 32'd5};
        tbl[12] = '{1'b0, 1'b0, 32'h00, 32'd8,  32'hC0DE_0004, 32'd8,  1'b1, 1'b0, 32'd6};
        tbl[13] = '{1'b0, 1'b1, 32'h40, 32'h40, 32'h0,         32'd0,  1'b0, 1'b0, 32'd6};
        tbl[14] = '{1'b0, 1'b0, 32'h00, 32'h40, 32'h0,         32'd0,  1'b0, 1'b1, 32'd6};
        tbl[15] = '{1'b0, 1'b1, 32'h00, 32'd0,  32'h0,         32'd0,  1'b0, 1'b0, 32'd6};
        tbl[16] = '{1'b0, 1'b0, 32'h00, 32'd4,  32'hC0DE_0000, 32'd4,  1'b1, 1'b0, 32'd7};

        // Reset state
        #12;
        check("reset_pc", pc, 32'h0);
        check("reset_imem_addr", imem_addr, 32'h0);
        check("reset_instr", if_id_instr, 32'h0);
        check("reset_pc4", if_id_pc4, 32'h0);
        check("reset_valid", 32'(if_id_valid), 32'h0);
        check("reset_done", 32'(fetch_done), 32'h0);
        check("reset_count", fetch_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // First edge after release was a normal fetch of word@0; realign the table.
        check("first_fetch_pc", pc, 32'd4);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].stall, tbl[i].redirect, tbl[i].rpc);
            check($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
            check($sformatf("vec%0d_imem_addr", i), imem_addr, tbl[i].e_pc);
            check($sformatf("vec%0d_instr", i), if_id_instr, tbl[i].e_instr);
            if (tbl[i].e_valid)
                check($sformatf("vec%0d_pc4", i), if_id_pc4, tbl[i].e_pc4);
            check($sformatf("vec%0d_valid", i), 32'(if_id_valid), 32'(tbl[i].e_valid));
            check($sformatf("vec%0d_done", i), 32'(fetch_done), 32'(tbl[i].e_done));
            check($sformatf("vec%0d_count", i), fetch_count, tbl[i].e_count);
        end

        // Asynchronous reset mid-cycle while pc=12 and IF/ID valid
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("pre_areset_pc", pc, 32'd12);
        check("pre_areset_valid", 32'(if_id_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_pc", pc, 32'h0);
        check("areset_valid", 32'(if_id_valid), 32'h0);
        check("areset_count", fetch_count, 32'h0);
        check("areset_instr", if_id_instr, 32'h0);
        check("areset_done", 32'(fetch_done), 32'h0);
        @(posedge clk);
        #1;
        check("areset_hold_pc", pc, 32'h0);
        rst_n = 1'b1;
        model_reset();

        // Randomized stall/redirect traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic        s, r;
            logic [31:0] rp;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
            model_step(s, r, rp);
            step(s, r, rp);
            check("rand_pc", pc, m_pc);
            check("rand_instr", if_id_instr, m_instr);
            if (m_valid) check("rand_pc4", if_id_pc4, m_pc4);
            check("rand_valid", 32'(if_id_valid), 32'(m_valid));
            check("rand_done", 32'(fetch_done), 32'(m_done));
            check("rand_count", fetch_count, m_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
